arb_mux_4_1: RTL and testbench

ARB_MUX_4_1 -- requirements
Module: arb_mux_4_1

---
 rtl/arb_mux_4_1.sv | 80 ++++++++
 tb/tb_arb_mux_4_1.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/arb_mux_4_1.sv
// Four-way round-robin arbiter feeding a single registered output slot.
// The output register refills on the same edge it drains, so a full stream runs at one item per cycle.
module arb_mux_4_1 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  output logic [WIDTH-1:0] y,
  output logic [1:0]       y_sel,
  output logic             y_valid,
  input  logic             y_ready
);

  logic [1:0]       ptr_q;
  logic [1:0]       winner;
  logic [1:0]       idx;
  logic             found;
  logic             load;
  logic             any_valid;
  logic [WIDTH-1:0] win_data;

  assign load      = !y_valid || y_ready;
  assign any_valid = |in_valid;

  // Scan from ptr upward, wrapping modulo 4; the first requesting index wins.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    idx    = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && in_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    unique case (winner)
      2'd0:    win_data = d0;
      2'd1:    win_data = d1;
      2'd2:    win_data = d2;
      default: win_data = d3;
    endcase
  end

  // Reset gates the grant combinationally so nothing is accepted and then lost.
  always_comb begin
    in_ready = 4'b0000;
    if (!rst && load && any_valid) begin
      in_ready = 4'b0001 << winner;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= '0;
      y_sel   <= 2'd0;
      y_valid <= 1'b0;
      ptr_q   <= 2'd0;
    end else if (load) begin
      if (any_valid) begin
        y       <= win_data;
        y_sel   <= winner;
        y_valid <= 1'b1;
        ptr_q   <= winner + 2'd1;
      end else begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_4_1.sv
// Randomized bench for arb_mux_4_1: a priority-order reference model plus an in-order scoreboard.
module tb_arb_mux_4_1;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] d [4];
  logic [3:0]       in_valid;
  logic [3:0]       in_ready;
  logic [WIDTH-1:0] y;
  logic [1:0]       y_sel;
  logic             y_valid;
  logic             y_ready;

  int checks = 0;
  int errors = 0;

  // Reference state, tracked arithmetically.
  int          m_ptr = 0;
  bit          m_yv  = 1'b0;
  int          m_y   = 0;
  int          m_sel = 0;
  logic [3:0]  last_rdy;
  logic [5:0]  sb_q [$];

  always #5 clk = ~clk;

  arb_mux_4_1 #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .d0       (d[0]),
    .d1       (d[1]),
    .d2       (d[2]),
    .d3       (d[3]),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y        (y),
    .y_sel    (y_sel),
    .y_valid  (y_valid),
    .y_ready  (y_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // One clock cycle: drive, check grant, clock, update model, check outputs.
  task automatic step(input logic r, input logic [3:0] v, input logic yr, input logic [15:0] dv);
    int         w;
    bit         ld;
    logic [3:0] exp_rdy;
    logic [5:0] it;
    @(negedge clk);
    rst      = r;
    in_valid = v;
    y_ready  = yr;
    for (int i = 0; i < 4; i++) d[i] = dv[i*4 +: 4];
    #1;
    w       = pick(v, m_ptr);
    ld      = !m_yv || yr;
    exp_rdy = (!r && ld && w >= 0) ? 4'(1 << w) : 4'b0000;
    last_rdy = in_ready;
    check("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
    check("onehot", 32'($countones(in_ready) <= 1), 32'd1);
    if (r) begin
      sb_q.delete();
    end else begin
      if (y_valid && y_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_empty", 32'(sb_q.size()), 32'd1);
        end else begin
          it = sb_q.pop_front();
          check("sb_y", {28'd0, y}, {28'd0, it[3:0]});
          check("sb_sel", {30'd0, y_sel}, {30'd0, it[5:4]});
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (in_ready[i] && in_valid[i]) sb_q.push_back({2'(i), d[i]});
      end
    end
    @(posedge clk);
    if (r) begin
      m_ptr = 0; m_yv = 1'b0; m_y = 0; m_sel = 0;
    end else if (ld) begin
      if (w >= 0) begin
        m_y = int'(dv[w*4 +: 4]); m_sel = w; m_yv = 1'b1; m_ptr = (w + 1) % 4;
      end else begin
        m_yv = 1'b0;
      end
    end
    #1;
    check("y_valid", {31'd0, y_valid}, {31'd0, m_yv});
    check("y", {28'd0, y}, 32'(m_y));
    check("y_sel", {30'd0, y_sel}, 32'(m_sel));
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 4'b0000;
    y_ready  = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = '0;

    step(1'b1, 4'b0000, 1'b1, 16'h0000);
    step(1'b1, 4'b1111, 1'b1, 16'hFFFF);
    check("rst_ready", {28'd0, last_rdy}, 32'd0);
    check("rst_yv", {31'd0, y_valid}, 32'd0);
    check("rst_y", {28'd0, y}, 32'd0);

    // All four requesting: strict rotation 0,1,2,3.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'b1111, 1'b1, 16'h4321);
      check("rr_ready", {28'd0, last_rdy}, 32'(1 << i));
      check("rr_y", {28'd0, y}, 32'(i + 1));
      check("rr_sel", {30'd0, y_sel}, 32'(i));
    end

    // Idle drain: valid drops, data and index hold.
    step(1'b0, 4'b0000, 1'b1, 16'h0000);
    check("drain_yv", {31'd0, y_valid}, 32'd0);
    check("drain_y", {28'd0, y}, 32'd4);
    check("drain_sel", {30'd0, y_sel}, 32'd3);

    // Grant 1 moves ptr to 2; grant 1 again from ptr 2 keeps ptr at 2.
    step(1'b0, 4'b0010, 1'b1, 16'h0090);
    step(1'b0, 4'b0010, 1'b1, 16'h0090);
    check("wrap1_ready", {28'd0, last_rdy}, 32'b0010);
    check("wrap1_y", {28'd0, y}, 32'd9);
    check("wrap1_sel", {30'd0, y_sel}, 32'd1);

    // Stall with item 5 from requester 2 held.
    step(1'b0, 4'b0000, 1'b1, 16'h0000);
    step(1'b0, 4'b0100, 1'b0, 16'h0500);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b1011, 1'b0, 16'h1234);
      check("stall_ready", {28'd0, last_rdy}, 32'd0);
      check("stall_y", {28'd0, y}, 32'd5);
      check("stall_sel", {30'd0, y_sel}, 32'd2);
    end
    step(1'b0, 4'b1011, 1'b1, 16'h1234);
    check("resume_ready", {28'd0, last_rdy}, 32'b1000);
    check("resume_sel", {30'd0, y_sel}, 32'd3);

    // Mid-stream reset discards the held item; priority restarts at 0.
    step(1'b1, 4'b1111, 1'b0, 16'h4321);
    check("mrst_ready", {28'd0, last_rdy}, 32'd0);
    check("mrst_yv", {31'd0, y_valid}, 32'd0);
    step(1'b0, 4'b1111, 1'b1, 16'h4321);
    check("mrst_grant", {28'd0, last_rdy}, 32'b0001);
    check("mrst_sel", {30'd0, y_sel}, 32'd0);

    for (int n = 0; n < 10000; n++) begin
      step(1'($urandom_range(0, 199) == 0), 4'($urandom), 1'($urandom), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
